// File: rtl/pipeline_defs.sv
// Shared fetch/decode/hazard definitions: widths, fetch FSM encodings and the IF/ID bundle.
package pipeline_defs;

  localparam int PC_W    = 32;  // word-addressed PC / instruction-memory address width
  localparam int INSTR_W = 16;  // instruction word width
  localparam int IMM_BIT = 0;   // opcode bit that announces a trailing immediate word

  typedef enum logic {
    FETCH_OP  = 1'b0,
    FETCH_IMM = 1'b1
  } fetch_state_e;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  // IF/ID pipeline register contents handed to decode.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] imm;
    logic [PC_W-1:0]    pc_next;
    logic               valid;
  } ifid_t;

  // A bubble clears the instruction fields but leaves PC_Next where it was.
  function automatic ifid_t make_bubble(input ifid_t cur);
    ifid_t b;
    b         = cur;
    b.instr   = NOP_INSTR;
    b.imm     = NOP_INSTR;
    b.valid   = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: hazard/redirect controls, instruction memory and IF/ID outputs.
interface fetch_stage_if;
  import pipeline_defs::*;

  logic               Keep_PC;
  logic               Keep_Fetched_Instruction;
  logic               Redirect;
  logic [PC_W-1:0]    Redirect_PC;
  logic [PC_W-1:0]    IMem_Addr;
  logic [INSTR_W-1:0] IMem_Data;
  logic [INSTR_W-1:0] IFID_Instr;
  logic [INSTR_W-1:0] IFID_Imm;
  logic [PC_W-1:0]    IFID_PC_Next;
  logic               IFID_Valid;

  // Fetch stage side.
  modport master (
    input  Keep_PC, Keep_Fetched_Instruction, Redirect, Redirect_PC, IMem_Data,
    output IMem_Addr, IFID_Instr, IFID_Imm, IFID_PC_Next, IFID_Valid
  );

  // Surrounding pipeline / memory side.
  modport slave (
    output Keep_PC, Keep_Fetched_Instruction, Redirect, Redirect_PC, IMem_Data,
    input  IMem_Addr, IFID_Instr, IFID_Imm, IFID_PC_Next, IFID_Valid
  );

endinterface

// File: rtl/pc_register.sv
// Program counter flop: reset value, redirect load, stall hold, otherwise increment.
module pc_register #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_pc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;

  // PC update: reset > load > hold > increment (wraps modulo 2^PC_W).
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)          pc_q <= RESET_PC;
    else if (load_i)  pc_q <= load_pc_i;
    else if (!hold_i) pc_q <= pc_q + PC_W'(1);
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage + IF/ID register: assembles one- and two-word instructions, honours stalls and redirects.
module fetch_stage
  import pipeline_defs::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
  ifid_t              ifid_q, ifid_d;
  logic [PC_W-1:0]    pc;
  logic               has_imm;

  assign has_imm = bus.IMem_Data[IMM_BIT];

  // Redirect wins over Keep_PC inside the PC register, matching the stage priority.
  pc_register #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .hold_i    (bus.Keep_PC),
    .load_i    (bus.Redirect),
    .load_pc_i (bus.Redirect_PC),
    .pc_o      (pc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH_OP;
    else     state_q <= state_d;
  end

  // FSM next state: redirect restarts at an opcode; Keep_PC freezes the sequence.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (bus.Redirect) begin
      state_d = FETCH_OP;
    end else if (!bus.Keep_PC) begin
      case (state_q)
        FETCH_OP:  if (has_imm) state_d = FETCH_IMM;
        FETCH_IMM: state_d = FETCH_OP;
        default:   state_d = FETCH_OP;
      endcase
    end
  end

  // FSM outputs: hold register capture and next IF/ID contents.
  always_comb begin
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    ifid_d       = ifid_q;
    if (bus.Redirect) begin
      // Anything in flight is on the wrong path, including a stalled IF/ID entry.
      hold_instr_d = NOP_INSTR;
      hold_pc_d    = '0;
      ifid_d       = make_bubble(ifid_q);
    end else begin
      if (!bus.Keep_PC && state_q == FETCH_OP && has_imm) begin
        hold_instr_d = bus.IMem_Data;
        hold_pc_d    = pc;
      end
      if (!bus.Keep_Fetched_Instruction) begin
        if (bus.Keep_PC) begin
          ifid_d = make_bubble(ifid_q);
        end else begin
          case (state_q)
            FETCH_OP: begin
              if (has_imm) ifid_d = make_bubble(ifid_q);
              else         ifid_d = '{instr: bus.IMem_Data, imm: NOP_INSTR,
                                      pc_next: pc + PC_W'(1), valid: 1'b1};
            end
            FETCH_IMM: ifid_d = '{instr: hold_instr_q, imm: bus.IMem_Data,
                                  pc_next: hold_pc_q + PC_W'(2), valid: 1'b1};
            default:   ifid_d = make_bubble(ifid_q);
          endcase
        end
      end
    end
  end

  // Hold register and IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      ifid_q       <= '0;
    end else begin
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      ifid_q       <= ifid_d;
    end
  end

  assign bus.IMem_Addr    = pc;
  assign bus.IFID_Instr   = ifid_q.instr;
  assign bus.IFID_Imm     = ifid_q.imm;
  assign bus.IFID_PC_Next = ifid_q.pc_next;
  assign bus.IFID_Valid   = ifid_q.valid;

endmodule
